// File: rtl/bit4_up_counter_pkg.sv
// Shared constants and next-state operation encoding for the bit4_up_counter slice.
// The operation selector captures the load > count > hold priority in one place.
package bit4_up_counter_pkg;

  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } count_op_t;

  // Load always wins; direction only matters when the count enable is active.
  function automatic count_op_t select_op(input logic loaden,
                                          input logic clken,
                                          input logic up);
    count_op_t op;
    op = OP_HOLD;
    if (loaden) begin
      op = OP_LOAD;
    end else if (clken) begin
      op = up ? OP_INC : OP_DEC;
    end
    return op;
  endfunction

endpackage

// File: rtl/bit4_up_counter_next.sv
// Combinational next-count logic: load / increment / decrement / hold mux.
// Arithmetic wraps naturally at the register width.
module bit4_up_counter_next
  import bit4_up_counter_pkg::*;
#(
  parameter int WIDTH = COUNT_W
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] load,
  input  logic             loaden,
  input  logic             clken,
  input  logic             up,
  output logic [WIDTH-1:0] count_next
);

  count_op_t op;

  always_comb begin
    op         = select_op(loaden, clken, up);
    count_next = count;
    case (op)
      OP_LOAD: count_next = load;
      OP_INC:  count_next = count + WIDTH'(1);
      OP_DEC:  count_next = count - WIDTH'(1);
      default: count_next = count;
    endcase
  end

endmodule

// File: rtl/bit4_up_counter.sv
// Four-bit up/down counter with synchronous parallel load and count enable.
// Holds only the count register; the output is driven straight from it.
module bit4_up_counter
  import bit4_up_counter_pkg::*;
#(
  parameter int WIDTH = COUNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load,
  input  logic             loaden,
  input  logic             clken,
  input  logic             up,
  output logic [WIDTH-1:0] countout
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;

  bit4_up_counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .count      (count),
    .load       (load),
    .loaden     (loaden),
    .clken      (clken),
    .up         (up),
    .count_next (count_next)
  );

  // The port is named reset but is active-low, so any pending load is dropped at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign countout = count;

endmodule

// File: tb/tb_bit4_up_counter.sv
// Scoreboard bench for bit4_up_counter: expected counts are queued as stimulus is
// driven on the falling edge and popped/compared just after each rising edge.
module tb_bit4_up_counter;
  import bit4_up_counter_pkg::*;

  localparam int W = COUNT_W;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] load;
  logic         loaden;
  logic         clken;
  logic         up;
  logic [W-1:0] countout;

  int           check_count = 0;
  int           error_count = 0;
  logic [W-1:0] model_count;
  logic [W-1:0] expected_q[$];

  always #5 clk = ~clk;

  bit4_up_counter #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .loaden   (loaden),
    .clken    (clken),
    .up       (up),
    .countout (countout)
  );

  task automatic check_output(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, predict the count after the next rising edge, then compare.
  task automatic apply_stimulus(input string tag, input logic ld_en,
                                input logic [W-1:0] ld_val, input logic cen,
                                input logic dir);
    logic [W-1:0] expected;
    @(negedge clk);
    loaden = ld_en;
    load   = ld_val;
    clken  = cen;
    up     = dir;
    if (!reset)     model_count = '0;
    else if (ld_en) model_count = ld_val;
    else if (cen)   model_count = dir ? model_count + 1'b1 : model_count - 1'b1;
    expected_q.push_back(model_count);
    @(posedge clk);
    #1;
    if (expected_q.size() == 0) begin
      check_output({tag, "_queue_empty"}, countout, ~countout);
    end else begin
      expected = expected_q.pop_front();
      check_output(tag, countout, expected);
    end
  endtask

  initial begin
    reset       = 1'b0;
    load        = '0;
    loaden      = 1'b0;
    clken       = 1'b0;
    up          = 1'b0;
    model_count = '0;

    #2;
    check_output("reset_state", countout, 4'h0);
    apply_stimulus("reset_held_count", 1'b0, 4'h0, 1'b1, 1'b1);
    apply_stimulus("reset_held_load", 1'b1, 4'h9, 1'b0, 1'b1);

    @(negedge clk);
    loaden = 1'b0;
    clken  = 1'b0;
    reset  = 1'b1;

    // Reach 7 and assert reset mid-cycle with no clock edge in between.
    apply_stimulus("load_7", 1'b1, 4'h7, 1'b0, 1'b0);
    @(negedge clk);
    loaden = 1'b1;
    load   = 4'h5;
    #2;
    reset = 1'b0;
    #1;
    check_output("async_reset", countout, 4'h0);
    model_count = '0;
    expected_q.delete();
    apply_stimulus("reset_discards_load", 1'b1, 4'h5, 1'b1, 1'b1);
    @(negedge clk);
    loaden = 1'b0;
    clken  = 1'b0;
    reset  = 1'b1;

    $display("[TB] load and hold");
    apply_stimulus("load_a", 1'b1, 4'b1010, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) apply_stimulus("hold_a", 1'b0, 4'h0, 1'b0, i[0]);

    $display("[TB] count up through wrap");
    for (int i = 0; i < 7; i++) apply_stimulus("count_up", 1'b0, 4'h0, 1'b1, 1'b1);
    check_output("up_end_value", countout, 4'h1);

    $display("[TB] count down through wrap");
    for (int i = 0; i < 3; i++) apply_stimulus("count_down", 1'b0, 4'h0, 1'b1, 1'b0);
    check_output("down_end_value", countout, 4'hE);

    $display("[TB] load priority over count");
    apply_stimulus("load_3", 1'b1, 4'h3, 1'b0, 1'b0);
    apply_stimulus("load_beats_inc", 1'b1, 4'hA, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) apply_stimulus("load_held", 1'b1, 4'hA, i[0], 1'b1);

    $display("[TB] enable gating");
    for (int i = 0; i < 10; i++) apply_stimulus("gated", 1'b0, W'($urandom), 1'b0, i[0]);
    for (int i = 0; i < 3; i++) apply_stimulus("regate_down", 1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) apply_stimulus("regate_up", 1'b0, 4'h0, 1'b1, 1'b1);
    check_output("regate_end_value", countout, 4'h9);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      apply_stimulus("random", ($urandom_range(0, 5) == 0), W'($urandom),
                     ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
